// File: rtl/noc_ni_pkg.sv
// Shared definitions for the core transmit NI: flit types, field positions, FSM states, flit assembly.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable; the functions only assemble flit words.
package noc_ni_pkg;

    localparam logic [2:0]  FLIT_HEAD   = 3'b001;
    localparam logic [2:0]  FLIT_BODY   = 3'b010;
    localparam logic [2:0]  FLIT_TAIL   = 3'b100;
    localparam logic [2:0]  FLIT_IDLE   = 3'b011;

    localparam logic [31:0] IDLE_FLIT_C = 32'h6000_0000;

    localparam int TYPE_LSB  = 29;
    localparam int VC_LSB    = 27;
    localparam int DEST_LSB  = 19;
    localparam int SRC_LSB   = 11;

    localparam int ADDR_W_C  = 8;
    localparam int PAYLOAD_W = 27;
    localparam int VC_W      = 2;
    localparam int NUM_VC_C  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } ni_state_e;

    // One buffered core word; dest is only meaningful on the first word of a packet.
    typedef struct packed {
        logic [ADDR_W_C-1:0]  dest;
        logic                 last;
        logic [PAYLOAD_W-1:0] data;
    } ni_entry_t;

    // Builds a flit from its type, VC index (VC number minus 1) and 27-bit body.
    function automatic logic [31:0] make_flit(input logic [2:0]           ftype,
                                              input logic [VC_W-1:0]      vc,
                                              input logic [PAYLOAD_W-1:0] body);
        logic [31:0] f;
        f = '0;
        f[TYPE_LSB +: 3]    = ftype;
        f[VC_LSB +: VC_W]   = vc;
        f[PAYLOAD_W-1:0]    = body;
        return f;
    endfunction

    // HEAD body: destination, source, low bits zero.
    function automatic logic [PAYLOAD_W-1:0] head_body(input logic [ADDR_W_C-1:0] dest,
                                                       input logic [ADDR_W_C-1:0] src);
        logic [PAYLOAD_W-1:0] p;
        p = '0;
        p[DEST_LSB +: ADDR_W_C] = dest;
        p[SRC_LSB +: ADDR_W_C]  = src;
        return p;
    endfunction

endpackage

// File: rtl/core_ni_tx_if.sv
// Core-to-NI word stream: valid/ready handshake carrying dest, payload and end-of-packet.
// Latency: none (wires only).
// Backpressure: core_ready low holds the core's current word.
interface core_ni_tx_if;
    import noc_ni_pkg::*;

    logic                 core_valid;
    logic                 core_ready;
    logic [ADDR_W_C-1:0]  core_dest;
    logic [PAYLOAD_W-1:0] core_data;
    logic                 core_last;

    modport master (
        output core_valid,
        output core_dest,
        output core_data,
        output core_last,
        input  core_ready
    );

    modport slave (
        input  core_valid,
        input  core_dest,
        input  core_data,
        input  core_last,
        output core_ready
    );
endinterface

// File: rtl/ni_sync_fifo.sv
// Synchronous first-word-fall-through FIFO buffering core words inside the NI.
// Latency: an entry pushed at edge t is visible on rdata_o right after edge t.
// Backpressure: full_o refuses a push unless a pop happens in the same cycle.
module ni_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
)(
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot, so a full FIFO can still take a word that cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/core_ni_tx.sv
// Core transmit NI: buffers core words, packetizes HEAD/BODY/TAIL, picks a VC round-robin.
// Latency: word accepted at edge t on an empty NI gives HEAD at edge t+2, BODY/TAIL from t+3.
// Backpressure: core_ready = FIFO not full; a full VC bit turns that cycle's launch into IDLE.
// Optional NI_STATS_EN adds saturating packet and stall counters; otherwise they read 0.
module core_ni_tx
    import noc_ni_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          NUM_VC    = NUM_VC_C,
    parameter int          ADDR_W    = ADDR_W_C,
    parameter logic [31:0] IDLE_FLIT = IDLE_FLIT_C
)(
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] current_address,
    core_ni_tx_if.slave       core_if,
    input  logic [NUM_VC-1:0] full_in_vc,
    output logic [31:0]       data_out_flit,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       stall_cnt
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ni_state_e        state_q, state_d;
    logic [VC_W-1:0]  vc_q, vc_d;
    logic [VC_W-1:0]  rr_q, rr_d;
    logic [31:0]      flit_q, flit_d;

    logic [VC_W-1:0]  pick;
    logic             found;

    ni_entry_t        push_entry;
    ni_entry_t        head;
    logic             push_fire;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    logic             more_after_pop;

    assign core_if.core_ready = !fifo_full;
    assign push_fire          = core_if.core_valid && !fifo_full;
    assign push_entry         = {core_if.core_dest, core_if.core_last, core_if.core_data};

    ni_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ni_entry_t))
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .push_i  (push_fire),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // After popping the TAIL, is there already another word to start a packet with?
    assign more_after_pop = (fifo_cnt > CNT_W'(1)) || push_fire;

    // Round-robin search: first free VC at or after the pointer (descending scan, lowest offset wins).
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (!full_in_vc[rr_q + VC_W'(i)]) begin
                found = 1'b1;
                pick  = rr_q + VC_W'(i);
            end
        end
    end

    // Packetizer FSM next state and flit selection; IDLE unless a flit actually launches.
    always_comb begin
        state_d  = state_q;
        vc_d     = vc_q;
        rr_d     = rr_q;
        flit_d   = IDLE_FLIT;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                // The head word stays in the FIFO; it becomes the first BODY/TAIL.
                if (found) begin
                    flit_d  = make_flit(FLIT_HEAD, pick, head_body(head.dest, current_address));
                    vc_d    = pick;
                    rr_d    = pick + VC_W'(1);
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (!fifo_empty && !full_in_vc[vc_q]) begin
                    fifo_pop = 1'b1;
                    if (head.last) begin
                        flit_d  = make_flit(FLIT_TAIL, vc_q, head.data);
                        state_d = more_after_pop ? S_HEAD : S_IDLE;
                    end else begin
                        flit_d  = make_flit(FLIT_BODY, vc_q, head.data);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, latched VC, arbitration pointer and registered flit output.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            vc_q    <= '0;
            rr_q    <= '0;
            flit_q  <= IDLE_FLIT;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            rr_q    <= rr_d;
            flit_q  <= flit_d;
        end
    end

    assign data_out_flit = flit_q;

`ifdef NI_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        tail_launch;
    logic        idle_stall;

    assign tail_launch = fifo_pop && head.last;
    assign idle_stall  = ((state_q == S_HEAD) || (state_q == S_BODY)) &&
                         (flit_d[TYPE_LSB +: 3] == FLIT_IDLE);

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (clr) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (tail_launch && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (idle_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign pkt_cnt   = 16'd0;
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_core_ni_tx.sv
// Directed self-checking bench for core_ni_tx.
// Latency: checks HEAD at t+2 / TAIL at t+3 for a lone word.
// Backpressure: exercises VC full flags, full FIFO and clr mid-packet.
`timescale 1ns/1ps
module tb_core_ni_tx;

    localparam logic [31:0] IDLE = 32'h6000_0000;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  current_address = 8'h00;
    logic [3:0]  full_in_vc = 4'b0000;
    logic [31:0] data_out_flit;
    logic [15:0] pkt_cnt;
    logic [15:0] stall_cnt;

    core_ni_tx_if cif();

    core_ni_tx #(.DEPTH(8)) dut (
        .clk             (clk),
        .clr             (clr),
        .current_address (current_address),
        .core_if         (cif),
        .full_in_vc      (full_in_vc),
        .data_out_flit   (data_out_flit),
        .pkt_cnt         (pkt_cnt),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] cap_q[$];
    logic [31:0] fl_q[$];
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) cap_q.push_back(data_out_flit);
    end

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] dest, input logic [26:0] data, input logic last);
        int n;
        @(negedge clk);
        cif.core_valid = 1'b1;
        cif.core_dest  = dest;
        cif.core_data  = data;
        cif.core_last  = last;
        n = 0;
        while (!cif.core_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got=core_ready 0 exp=core_ready 1");
        end
        @(posedge clk);
        #1;
        cif.core_valid = 1'b0;
    endtask

    task automatic start_cap();
        cap_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic stop_cap(input int n);
        repeat (n) @(negedge clk);
        mon_en = 1'b0;
        fl_q.delete();
        foreach (cap_q[i]) if (cap_q[i] !== IDLE) fl_q.push_back(cap_q[i]);
    endtask

    task automatic test_reset();
        int nonidle;
        do_reset();
        checks++;
        if (data_out_flit !== IDLE) begin
            errors++;
            $display("FAIL reset_flit got=%h exp=%h", data_out_flit, IDLE);
        end
        checks++;
        if (cif.core_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", cif.core_ready);
        end
        nonidle = 0;
        repeat (6) begin
            @(negedge clk);
            if (data_out_flit !== IDLE) nonidle++;
        end
        checks++;
        if (nonidle != 0) begin
            errors++;
            $display("FAIL reset_stays_idle got=%0d exp=0", nonidle);
        end
`ifdef NI_STATS_EN
        checks++;
        if (pkt_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", pkt_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_single_word();
        logic [31:0] exp [5];
        exp[0] = IDLE;
        exp[1] = IDLE;
        exp[2] = 32'h2088_0000;
        exp[3] = 32'h8000_0ABC;
        exp[4] = IDLE;
        current_address = 8'h00;
        full_in_vc = 4'b0000;
        push_word(8'h11, 27'h0000ABC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (data_out_flit !== exp[i]) begin
                errors++;
                $display("FAIL single_word[%0d] got=%h exp=%h", i, data_out_flit, exp[i]);
            end
        end
    endtask

    task automatic test_vc_select();
        logic [31:0] got;
        full_in_vc = 4'b0001;
        start_cap();
        push_word(8'h11, 27'h1234567, 1'b0);
        push_word(8'h11, 27'h7654321, 1'b0);
        push_word(8'h11, 27'h0000001, 1'b1);
        stop_cap(10);
        exp_q = '{32'h2888_0000, 32'h4923_4567, 32'h4F65_4321, 32'h8800_0001};
        checks++;
        if (fl_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL vc2_count got=%0d exp=%0d", fl_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < fl_q.size()) ? fl_q[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL vc2_flit[%0d] got=%h exp=%h", i, got, exp_q[i]);
            end
        end
        // Pointer advanced past VC2, so a fresh packet lands on VC3.
        full_in_vc = 4'b0000;
        start_cap();
        push_word(8'h11, 27'h0000003, 1'b1);
        stop_cap(8);
        exp_q = '{32'h3088_0000, 32'h9000_0003};
        checks++;
        if (fl_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL vc3_count got=%0d exp=%0d", fl_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < fl_q.size()) ? fl_q[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL vc3_flit[%0d] got=%h exp=%h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] got;
        bit seen_body;
        int hi, ti, idles;
        do_reset();
        current_address = 8'h00;
        full_in_vc = 4'b0000;
        start_cap();
        push_word(8'h05, 27'h11, 1'b0);
        push_word(8'h05, 27'h22, 1'b0);
        push_word(8'h05, 27'h33, 1'b0);
        push_word(8'h05, 27'h44, 1'b1);
        seen_body = 1'b0;
        for (int k = 0; k < 20 && !seen_body; k++) begin
            @(negedge clk);
            if (data_out_flit[31:29] == 3'b010) seen_body = 1'b1;
        end
        checks++;
        if (!seen_body) begin
            errors++;
            $display("FAIL stall_first_body got=none exp=BODY within 20 cycles");
        end
        full_in_vc = 4'b0001;
        repeat (3) @(negedge clk);
        full_in_vc = 4'b0000;
        stop_cap(10);
        exp_q = '{32'h2028_0000, 32'h4000_0011, 32'h4000_0022, 32'h4000_0033, 32'h8000_0044};
        checks++;
        if (fl_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=%0d", fl_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < fl_q.size()) ? fl_q[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_flit[%0d] got=%h exp=%h", i, got, exp_q[i]);
            end
        end
        hi = -1;
        ti = -1;
        foreach (cap_q[i]) begin
            if (cap_q[i][31:29] == 3'b001 && hi < 0) hi = i;
            if (cap_q[i][31:29] == 3'b100 && ti < 0) ti = i;
        end
        idles = 0;
        if (hi >= 0 && ti > hi) begin
            for (int i = hi + 1; i < ti; i++) if (cap_q[i] === IDLE) idles++;
        end
        checks++;
        if (idles != 3) begin
            errors++;
            $display("FAIL stall_idle_gap got=%0d exp=3", idles);
        end
`ifdef NI_STATS_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_cnt got=%0d exp=3", stall_cnt);
        end
`endif
    endtask

    task automatic test_fifo_full();
        logic [31:0] got;
        do_reset();
        current_address = 8'h00;
        full_in_vc = 4'b1111;
        for (int i = 0; i < 8; i++) push_word(8'h7E, 27'h100 + 27'(i), (i == 7));
        @(negedge clk);
        checks++;
        if (cif.core_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_after8 got=%b exp=0", cif.core_ready);
        end
        cif.core_valid = 1'b1;
        cif.core_dest  = 8'h7E;
        cif.core_data  = 27'h1FF;
        cif.core_last  = 1'b1;
        @(negedge clk);
        checks++;
        if (cif.core_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_ninth got=%b exp=0", cif.core_ready);
        end
        cif.core_valid = 1'b0;
        start_cap();
        full_in_vc = 4'b0000;
        stop_cap(20);
        exp_q.delete();
        exp_q.push_back(32'h23F0_0000);
        for (int i = 0; i < 7; i++) exp_q.push_back(32'h4000_0100 + 32'(i));
        exp_q.push_back(32'h8000_0107);
        checks++;
        if (fl_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL drain_count got=%0d exp=%0d", fl_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < fl_q.size()) ? fl_q[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL drain_flit[%0d] got=%h exp=%h", i, got, exp_q[i]);
            end
        end
        checks++;
        if (cif.core_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_ready got=%b exp=1", cif.core_ready);
        end
`ifdef NI_STATS_EN
        checks++;
        if (pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pkt_cnt got=%0d exp=1", pkt_cnt);
        end
`endif
    endtask

    task automatic test_clr_mid_packet();
        logic [31:0] got;
        bit seen_body;
        int nonidle;
        do_reset();
        current_address = 8'h00;
        full_in_vc = 4'b0000;
        push_word(8'h09, 27'hA1, 1'b0);
        push_word(8'h09, 27'hA2, 1'b0);
        push_word(8'h09, 27'hA3, 1'b0);
        push_word(8'h09, 27'hA4, 1'b1);
        seen_body = 1'b0;
        for (int k = 0; k < 20 && !seen_body; k++) begin
            @(negedge clk);
            if (data_out_flit[31:29] == 3'b010) seen_body = 1'b1;
        end
        checks++;
        if (!seen_body) begin
            errors++;
            $display("FAIL clr_first_body got=none exp=BODY within 20 cycles");
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (data_out_flit !== IDLE) begin
            errors++;
            $display("FAIL clr_idle got=%h exp=%h", data_out_flit, IDLE);
        end
        checks++;
        if (cif.core_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_ready got=%b exp=1", cif.core_ready);
        end
        nonidle = 0;
        repeat (8) begin
            @(negedge clk);
            if (data_out_flit !== IDLE) nonidle++;
        end
        checks++;
        if (nonidle != 0) begin
            errors++;
            $display("FAIL clr_discard got=%0d non-idle exp=0", nonidle);
        end
        current_address = 8'h35;
        start_cap();
        push_word(8'h22, 27'h5, 1'b1);
        stop_cap(8);
        exp_q = '{32'h2111_A800, 32'h8000_0005};
        checks++;
        if (fl_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL post_clr_count got=%0d exp=%0d", fl_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < fl_q.size()) ? fl_q[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL post_clr_flit[%0d] got=%h exp=%h", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        cif.core_valid = 1'b0;
        cif.core_dest  = 8'h00;
        cif.core_data  = 27'h0;
        cif.core_last  = 1'b0;
        test_reset();
        test_single_word();
        test_vc_select();
        test_stall();
        test_fifo_full();
        test_clr_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/core_ni_tx.md
Name: core_ni_tx

Overview:
Transmit-side network interface between a core and its mesh/torus router's core input port.
- Accepts a word stream from the core over a valid/ready handshake and buffers it in a local FIFO.
- Packetizes each message into HEAD, BODY…, TAIL flits and drives the router's 32-bit data_in_core.
- Selects a virtual channel per packet and obeys the router's full_out_core_vc backpressure.
- Drives the idle pattern whenever no flit is being launched.

Parameters:
DEPTH, 8, payload FIFO entries (power of 2, at least 2)
NUM_VC, 4, virtual channels on the core port (fixed at 4 for this network)
ADDR_W, 8, node address width; address = 16*row + col
IDLE_FLIT, 32'h6000_0000, word driven when no flit is launched

Ports:
clk  in  1  clock
clr  in  1  synchronous active-high reset
current_address  in  8  this node's address; used as the source field
core_valid  in  1  core word valid
core_ready  out  1  FIFO can accept a word (= FIFO not full)
core_dest  in  8  destination address; sampled only on the first word of a packet
core_data  in  27  payload word
core_last  in  1  marks the final word of a packet
full_in_vc  in  4  router core-port VC full flags; bit v-1 = VC v
data_out_flit  out  32  flit to router data_in_core; registered
pkt_cnt  out  16  packets fully sent (NI_STATS_EN only)
stall_cnt  out  16  backpressure stall cycles (NI_STATS_EN only)

Behaviour:
- Clocking and reset: one clock, clk. clr is synchronous and active-high.
- Reset values: data_out_flit=IDLE_FLIT; FIFO empty; core_ready=1; state S_IDLE; VC round-robin pointer=0; counters=0.
- Flit format:
  - [31:29] type: 001 HEAD, 010 BODY, 100 TAIL, 011 IDLE.
  - [28:27] VC number minus 1.
  - HEAD: [26:19] dest, [18:11] src=current_address, [10:0]=0.
  - BODY/TAIL: [26:0] payload.
- Core handshake:
  - A word is accepted on any cycle with core_valid && core_ready.
  - Each FIFO entry stores {dest, last, data}.
  - A push and a pop may occur in the same cycle even when the FIFO is full.
- Packet structure: an n-word packet produces 1+n flits. The HEAD carries no payload. Words 1..n-1 become BODY flits; word n (last=1) becomes the TAIL.
- FSM:
  - S_IDLE: FIFO non-empty → S_HEAD.
  - S_HEAD: choose the first VC at or after the pointer with full_in_vc clear. Launch the HEAD using the dest of the FIFO head entry; do not pop. Latch the VC; pointer = chosen+1 mod 4; → S_BODY. If all 4 VCs are full, launch IDLE and stay.
  - S_BODY: if the FIFO is non-empty and the latched VC is not full, pop one entry and launch BODY, or TAIL if last=1. After the TAIL → S_IDLE, or directly to S_HEAD if the FIFO is still non-empty. Otherwise launch IDLE (a stall).
- Launch rule: the output register loads a non-idle flit only if the target VC's full bit is 0 in that same cycle. Every non-idle flit is present for exactly one cycle.
- Latency: a word accepted at cycle t with the FIFO empty appears on data_out_flit as HEAD at edge t+2, and its BODY/TAIL at edge t+3 at the earliest.
- Packet granularity: a VC is never changed mid-packet, and packets never interleave.
- core_dest == current_address is legal; the packet is sent normally.
- clr mid-packet: the partial packet and all FIFO contents are discarded; IDLE is driven from the next edge.

Optional Feature:
Macro NI_STATS_EN.
- Defined:
  - pkt_cnt increments on each TAIL launch.
  - stall_cnt increments on each S_HEAD/S_BODY cycle that launches IDLE.
  - Both counters saturate at 16'hFFFF and are cleared by clr.
- Undefined: pkt_cnt and stall_cnt are tied to 0 and no counter logic exists.

Decomposition:
- Package noc_ni_pkg: flit type localparams (HEAD, BODY, TAIL, IDLE), the IDLE_FLIT constant, field bit positions, a state enum, and a flit-assembly function.
- Sub-module ni_sync_fifo (DEPTH × 36 bits; push/pop, full/empty, simultaneous push+pop). The FSM, VC arbitration and counters stay in core_ni_tx.

Test Plan:
1. Reset → clr held high 2 cycles → data_out_flit=32'h6000_0000, core_ready=1; stays idle with core_valid=0.
2. Single-word packet: current_address=8'h00, dest 8'h11, data 27'h0000ABC, all VCs free → HEAD 32'h2088_0000, then TAIL 32'h8000_0ABC, then 32'h6000_0000.
3. Three-word packet with full_in_vc=4'b0001 → VC2 chosen: HEAD 32'h2888_0000, then BODY 32'h4800_0000|d0, BODY |d1, TAIL 32'h8800_0000|d2. The next packet uses VC3.
4. Latched VC held full for 3 cycles mid-packet → exactly 3 IDLE flits, then resume; no word lost or duplicated; stall_cnt=3 with NI_STATS_EN.
5. FIFO fill: all VCs full, push 9 words → core_ready drops after 8 accepts. Release → all 8 words drain in order as one packet (HEAD, 7 BODY/TAIL per last flags); pkt_cnt increments per TAIL.
6. clr asserted after the HEAD plus one BODY of a 4-word packet → IDLE on the next edge, FIFO empty, core_ready=1. A following 1-word packet produces a correct HEAD/TAIL pair on VC1 (pointer reset).
